// File: rtl/dpram_lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dpram_lsu_ctrl: byte/half/word load-store sequencer for a 2-port x8 RAM.  |
// | Optional alignment/size checking: DPRAM_CTRL_ERR_EN.                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dpram_lsu_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [7:0]        ram_din_a,
  output logic [7:0]        ram_din_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [7:0]        ram_dout_a,
  input  logic [7:0]        ram_dout_b
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t              state;
  logic                we_q;
  logic [1:0]          size_q;
  logic                zext_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_hi;
  logic [31:0]         rbytes;

  logic [1:0]          eff_size;
  logic [ADDR_W-1:0]   eff_addr;
  logic                bad;
  logic [31:0]         beat0_bytes;
  logic [31:0]         beat1_bytes;

  always_comb begin
    eff_size = req_size;
    eff_addr = req_addr;
    bad      = 1'b0;
`ifdef DPRAM_CTRL_ERR_EN
    bad = (req_size == 2'b11) ||
          (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    // Without checking, illegal size behaves as word and low bits are dropped.
    if (req_size == 2'b11) eff_size = 2'b10;
    if (eff_size == 2'b01) eff_addr[0] = 1'b0;
    else if (eff_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
  end

  // Final beat's read data is folded in directly so the response is ready on RESP entry.
  assign beat0_bytes = {rbytes[31:16], ram_dout_b, ram_dout_a};
  assign beat1_bytes = {ram_dout_b, ram_dout_a, rbytes[15:0]};

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic zext,
                                              input logic [31:0] raw);
    case (size)
      2'b00:   extend_load = zext ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   extend_load = zext ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: extend_load = raw;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      ram_addr_a <= '0;
      ram_addr_b <= '0;
      ram_din_a  <= '0;
      ram_din_b  <= '0;
      ram_we_a   <= 1'b0;
      ram_we_b   <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      zext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_hi   <= '0;
      rbytes     <= '0;
    end else begin
      rsp_valid  <= 1'b0;
      ram_we_a   <= 1'b0;
      ram_we_b   <= 1'b0;
      ram_addr_a <= '0;
      ram_addr_b <= '0;
      ram_din_a  <= '0;
      ram_din_b  <= '0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            size_q    <= eff_size;
            zext_q    <= req_unsigned;
            addr_q    <= eff_addr;
            wdata_hi  <= req_wdata[31:16];
            req_ready <= 1'b0;
            if (bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state      <= BEAT0;
              ram_addr_a <= eff_addr;
              ram_din_a  <= req_wdata[7:0];
              ram_we_a   <= req_we;
              if (eff_size != 2'b00) begin
                ram_addr_b <= eff_addr + ADDR_W'(1);
                ram_din_b  <= req_wdata[15:8];
                ram_we_b   <= req_we;
              end
            end
          end
        end
        BEAT0: begin
          if (!we_q) rbytes[15:0] <= {ram_dout_b, ram_dout_a};
          if (size_q == 2'b10) begin
            state      <= BEAT1;
            ram_addr_a <= addr_q + ADDR_W'(2);
            ram_addr_b <= addr_q + ADDR_W'(3);
            ram_din_a  <= wdata_hi[7:0];
            ram_din_b  <= wdata_hi[15:8];
            ram_we_a   <= we_q;
            ram_we_b   <= we_q;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_q ? 32'd0 : extend_load(size_q, zext_q, beat0_bytes);
          end
        end
        BEAT1: begin
          if (!we_q) rbytes[31:16] <= {ram_dout_b, ram_dout_a};
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= we_q ? 32'd0 : extend_load(size_q, zext_q, beat1_bytes);
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dpram_lsu_ctrl.md
# dpram_lsu_ctrl

Load/store sequencer between the core's data-memory request interface and the byte-wide 1024x8 dual-port data RAM. Accepts byte, halfword and word loads/stores with a valid/ready handshake and splits each into byte beats that use both RAM ports in parallel. Returns sign- or zero-extended load data and an alignment error flag on a single-cycle response. Sits in the memory stage, directly in front of the data RAM.

## Interface
- ADDR_W, 10, byte-address width; matches RAM depth of 2**ADDR_W bytes.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; request accepted on rising edge with req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, little-endian, low bytes used for byte/half.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  request rejected (misaligned or illegal size); valid with rsp_valid.
- ram_addr_a / ram_addr_b  out  ADDR_W  RAM port addresses.
- ram_din_a / ram_din_b  out  8  RAM write data.
- ram_we_a / ram_we_b  out  1  RAM write enables.
- ram_dout_a / ram_dout_b  in  8  RAM read data; combinational from address.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP. Reset state IDLE.
- IDLE: req_ready=1. On accept, register we/size/unsigned/addr/wdata. Error check: size 11, half with addr[0]=1, word with addr[1:0]!=0 -> RESP with error; else -> BEAT0.
- BEAT0: port A = addr, byte 0. Half/word: port B = addr+1, byte 1; byte: ram_we_b=0. Store: we asserted on used ports. Load: sample ram_dout_a/b into byte regs at edge ending the beat. Word -> BEAT1; else -> RESP.
- BEAT1 (word only): port A = addr+2 (byte 2), port B = addr+3 (byte 3); same store/load rules -> RESP.
- RESP: rsp_valid=1, rsp_err per check, rsp_rdata assembled little-endian, extended per size/req_unsigned -> IDLE.
- Ports A and B never address the same byte in one beat; no write collision possible. Aligned accesses never exceed address 2**ADDR_W-1, so no wrap-around occurs.
- Errors perform no RAM access: ram_we_a/b stay 0.
- Outside beats: ram_addr_a/b=0, ram_din_a/b=0, ram_we_a/b=0.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, all ram_* outputs 0, byte regs 0.
- Accept at edge T: byte/half beat in cycle T+1, rsp_valid in cycle T+2; word beats T+1, T+2, rsp_valid T+3; error rsp_valid T+1.
- req_ready=0 in BEAT0/BEAT1/RESP; next accept earliest at edge ending RESP+1 (IDLE cycle). Max throughput: one word per 4 cycles.
- RAM writes commit at the edge ending the beat in which ram_we is high.
- rst mid-operation: immediate return to IDLE, ram_we deasserted asynchronously; bytes committed in earlier beats remain; no response issued for the aborted request.

## Configuration
- DPRAM_CTRL_ERR_EN defined: alignment/size checking as described; rsp_err driven.
- Not defined: no checking; low address bits forced aligned (half clears addr[0], word clears addr[1:0]); size 11 treated as word; rsp_err tied 0; every request takes the beat path.

## Test plan
- Store word 0xDEADBEEF at 0x010 -> RAM[0x010..0x013]=EF,BE,AD,DE; rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
- Then signed byte load 0x013 -> rsp_rdata=0xFFFFFFDE at T+2; unsigned half load 0x012 -> 0x0000DEAD.
- Word load 0x010 -> 0xDEADBEEF at T+3; req_ready low T+1..T+3, high T+4.
- With DPRAM_CTRL_ERR_EN: word store at 0x011 -> rsp_err=1 at T+1, no ram_we pulse, RAM unchanged; size 11 at 0x000 -> rsp_err=1.
- Word store 0x11223344 at 0x020, rst asserted during BEAT1 -> RAM[0x020]=44, RAM[0x021]=33, 0x022/0x023 unchanged, no rsp_valid, req_ready=1 after rst release.
- req_valid held high with two byte stores -> second accepted on edge after RESP cycle; both responses single-cycle pulses.
